if_fetch_stage: RTL

Instruction-fetch stage of the pipelined RV32 core: owns the fetch PC, drives a ready-handshaked instruction-memory port, and fills the IF/ID pipeline register whose instruction word feeds the decode-stage immediate generator and control unit. Handles decode-stage stalls with a one-entry holding buffer, and branch redirects and flushes by squashing wrong-path words.

---
 rtl/if_fetch_stage_if.sv | 22 ++
 rtl/if_fetch_stage.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus of the fetch stage.
// master = fetch stage (req/addr out), slave = memory (ready/data out).
interface if_fetch_stage_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_data_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ready_i,
        input  imem_data_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ready_i,
        output imem_data_i
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Fetch stage: owns the fetch PC, issues imem requests, fills IF/ID.
// Ports: clk_i/rst_i, start/stall/flush/branch controls, imem bus
// (master modport), IF/ID outputs pc_o/instr_o/valid_o.
module if_fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    stall_i,
    input  logic                    flush_i,
    input  logic                    branch_i,
    input  logic [31:0]             branch_target_i,
    if_fetch_stage_if.master        imem,
    output logic [31:0]             pc_o,
    output logic [31:0]             instr_o,
    output logic                    valid_o
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        drop_q, drop_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    logic [31:0] target;
    logic        load;
    logic        drain;
    state_t      after_st;

    assign target   = branch_target_i & 32'hFFFF_FFFC;
    assign after_st = start_i ? REQ : IDLE;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        buf_instr_d   = buf_instr_q;
        buf_pc_d      = buf_pc_q;
        drop_d        = drop_q;
        redirect_pc_d = redirect_pc_q;
        load          = 1'b0;
        drain         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (branch_i) fetch_pc_d = target;
                if (start_i) state_d = REQ;
            end
            REQ: begin
                if (imem.imem_ready_i) begin
                    if (drop_q) begin
                        // wrong-path word returns: discard it and
                        // resume at the most recent redirect
                        fetch_pc_d = branch_i ? target : redirect_pc_q;
                        drop_d     = 1'b0;
                        state_d    = after_st;
                    end else if (branch_i) begin
                        fetch_pc_d = target;
                    end else begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        if (stall_i && !flush_i) begin
                            buf_instr_d = imem.imem_data_i;
                            buf_pc_d    = fetch_pc_q;
                            state_d     = HOLD;
                        end else begin
                            load    = 1'b1;
                            state_d = after_st;
                        end
                    end
                end else if (branch_i) begin
                    // request cannot be withdrawn; finish it, then drop
                    drop_d        = 1'b1;
                    redirect_pc_d = target;
                end
            end
            HOLD: begin
                if (branch_i) begin
                    fetch_pc_d = target;
                    state_d    = after_st;
                end else if (flush_i) begin
                    state_d = after_st;
                end else if (!stall_i) begin
                    drain   = 1'b1;
                    state_d = after_st;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush_i || branch_i) begin
            instr_d = NOP;
            valid_d = 1'b0;
        end else if (stall_i) begin
            valid_d = valid_q;
        end else if (load) begin
            pc_d    = fetch_pc_q;
            instr_d = imem.imem_data_i;
            valid_d = 1'b1;
        end else if (drain) begin
            pc_d    = buf_pc_q;
            instr_d = buf_instr_q;
            valid_d = 1'b1;
        end else begin
            instr_d = NOP;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            fetch_pc_q    <= PC_RESET;
            buf_instr_q   <= NOP;
            buf_pc_q      <= PC_RESET;
            drop_q        <= 1'b0;
            redirect_pc_q <= PC_RESET;
            pc_q          <= PC_RESET;
            instr_q       <= NOP;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc_q      <= buf_pc_d;
            drop_q        <= drop_d;
            redirect_pc_q <= redirect_pc_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            valid_q       <= valid_d;
        end
    end

    // request side depends on registered state only
    assign imem.imem_req_o  = (state_q == REQ);
    assign imem.imem_addr_o = fetch_pc_q;

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule
